// File: rtl/insn_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// Master is the fetch/decode side, slave is the queue.
interface insn_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic [INSN_WIDTH-1:0] in_insn;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [INSN_WIDTH-1:0] out_insn;

  modport master (
    output in_valid, in_pc, in_insn, out_ready,
    input  in_ready, out_valid, out_pc, out_insn
  );

  modport slave (
    input  in_valid, in_pc, in_insn, out_ready,
    output in_ready, out_valid, out_pc, out_insn
  );
endinterface

// File: rtl/insn_queue.sv
// Fetch-to-decode instruction FIFO; NOP on the output when empty.
// Optional INSN_QUEUE_BYPASS_EN: zero-latency pass-through when empty.
module insn_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  insn_queue_if.slave              q,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INSN_WIDTH-1:0] insn;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW:0]   cnt;

  logic full;
  logic empty;
  logic byp;
  logic wr;
  logic rd;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

`ifdef INSN_QUEUE_BYPASS_EN
  assign byp = empty && q.in_valid && !flush && reset_n;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle is never stored
  assign wr = q.in_valid && !full && !flush && !(byp && q.out_ready);
  assign rd = !empty && q.out_ready && !flush;

  assign q.in_ready  = !full;
  assign q.out_valid = !empty || byp;
  assign count       = cnt;

  always_comb begin
    q.out_pc   = '0;
    q.out_insn = '0;
    unique case (1'b1)
      !empty: begin
        q.out_pc   = mem[rptr].pc;
        q.out_insn = mem[rptr].insn;
      end
      byp: begin
        q.out_pc   = q.in_pc;
        q.out_insn = q.in_insn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= '{pc: q.in_pc, insn: q.in_insn};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + PW'(1);
      if (rd) rptr <= rptr + PW'(1);
      cnt <= cnt + (PW+1)'(wr) - (PW+1)'(rd);
    end
  end
endmodule

// File: tb/tb_insn_queue.sv
// Self-checking bench for insn_queue: directed plan plus random traffic
// against a queue-based reference model.
module tb_insn_queue;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] insn;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic [$clog2(DEPTH):0] count;

  insn_queue_if #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) bus ();

  insn_queue #(
    .ADDR_WIDTH(AW), .INSN_WIDTH(IW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .q(bus.slave), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  ent_t mq[$];
  bit last_acc;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [AW-1:0] pc, logic [IW-1:0] insn,
                       bit ordy, bit fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_insn   = insn;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // Check outputs for the current inputs, then apply one clock edge
  task automatic cycle();
    int n;
    bit ev, acc, pop, byp;
    logic [AW-1:0] hp;
    logic [IW-1:0] hi;
    #1;
    n = mq.size();
    ev = (n > 0);
    byp = 1'b0;
    hp = '0;
    hi = '0;
    if (n > 0) begin
      hp = mq[0].pc;
      hi = mq[0].insn;
    end
`ifdef INSN_QUEUE_BYPASS_EN
    else if (bus.in_valid && !flush) begin
      ev = 1'b1;
      byp = 1'b1;
      hp = bus.in_pc;
      hi = bus.in_insn;
    end
`endif
    check("count", 64'(count), 64'(n));
    check("in_ready", 64'(bus.in_ready), 64'(n < DEPTH));
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    check("out_pc", 64'(bus.out_pc), 64'(hp));
    check("out_insn", 64'(bus.out_insn), 64'(hi));
    acc = bus.in_valid && (n < DEPTH) && !flush;
    pop = ev && bus.out_ready && !flush;
    if (flush) mq.delete();
    else if (!(byp && pop)) begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: bus.in_pc, insn: bus.in_insn});
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset();
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_insn", 64'(bus.out_insn), 64'd0);
    check("rst_out_pc", 64'(bus.out_pc), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] cpc;
    logic [IW-1:0] cins;
    reset_n = 1'b0;
    drive(1'b1, 32'h0, 32'h11, 1'b0, 1'b0);
    #3;
    check_reset();
    @(posedge clk);
    check_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // fill with no pops, then attempt a fifth push
    drive(1'b1, 32'h0, 32'h11, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h4, 32'h22, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h8, 32'h33, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hC, 32'h44, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h10, 32'h55, 1'b0, 1'b0); cycle();
    check("full_count", 64'(count), 64'd4);

    // drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();
    end

    // steady push/pop at count 2 across pointer wrap
    cpc = 32'h100;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, cpc, cpc ^ 32'hA5A5_0000, i >= 2, 1'b0);
      cycle();
      cpc += 4;
    end
    check("pp_count", 64'(count), 64'd2);

    // bring to 3 entries, flush with a concurrent push
    drive(1'b1, cpc, 32'h77, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h200, 32'h88, 1'b0, 1'b1); cycle();
    drive(1'b1, 32'h300, 32'h99, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
    check("flush_head", 64'(bus.out_pc), 64'h300);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();

    // empty queue, push with decode ready
    drive(1'b1, 32'h40, 32'hAB, 1'b1, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();

    // random traffic; fetch holds pc/insn until accepted
    cpc = 32'h1000;
    cins = $urandom;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2;
        reset_n = 1'b0;
        mq.delete();
        check_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      drive(($urandom % 4) != 0, cpc, cins, ($urandom % 3) != 0,
            ($urandom % 20) == 0);
      cycle();
      if (last_acc) begin
        cpc += 4;
        cins = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
